// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice:
// state encodings, opcode constants, instruction field positions and default data width.
package alu_pkg;

   localparam int DW_DEFAULT = 32;

   localparam logic [3:0] OP_NOP = 4'h0;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int SRCA_MSB = 7;
   localparam int SRCA_LSB = 4;
   localparam int SRCB_MSB = 3;
   localparam int SRCB_LSB = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_READ,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_FAULT
   } seq_state_t;

   function automatic logic [3:0] inst_opcode(input logic [15:0] inst);
      return inst[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] inst_src_a(input logic [15:0] inst);
      return inst[SRCA_MSB:SRCA_LSB];
   endfunction

   function automatic logic [3:0] inst_src_b(input logic [15:0] inst);
      return inst[SRCB_MSB:SRCB_LSB];
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of every signal between the ALU sequencer and its neighbours
// (slave, instruction FIFO, operand register file, ALU core, result FIFO).
// The master modport is the sequencer's view; slave is the surrounding environment.
interface alu_sequencer_if
   import alu_pkg::*;
   #(parameter int DW = DW_DEFAULT);

   logic          op_start;
   logic          inst_empty;
   logic          inst_rd_en;
   logic [DW-1:0] inst_dout;
   logic [3:0]    rf_addr_a;
   logic [3:0]    rf_addr_b;
   logic [DW-1:0] rf_data_a;
   logic [DW-1:0] rf_data_b;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic          alu_start;
   logic          alu_done;
   logic [DW-1:0] alu_result;
   logic          r_full;
   logic          r_wr_en;
   logic [DW-1:0] r_din;
   logic          op_done;
   logic          fault;
   logic          busy;
   logic [31:0]   inst_count;

   modport master (
      input  op_start, inst_empty, inst_dout, rf_data_a, rf_data_b,
             alu_done, alu_result, r_full,
      output inst_rd_en, rf_addr_a, rf_addr_b, alu_op, alu_a, alu_b,
             alu_start, r_wr_en, r_din, op_done, fault, busy, inst_count
   );

   modport slave (
      output op_start, inst_empty, inst_dout, rf_data_a, rf_data_b,
             alu_done, alu_result, r_full,
      input  inst_rd_en, rf_addr_a, rf_addr_b, alu_op, alu_a, alu_b,
             alu_start, r_wr_en, r_din, op_done, fault, busy, inst_count
   );

endinterface

// File: rtl/alu_seq_wdog.sv
// 8-bit saturating watchdog for the WAIT state. Cleared on issue, counts while
// enabled, and flags expiry on the TIMEOUT-th enabled cycle so the FSM can leave
// WAIT exactly TIMEOUT cycles after entering it.
module alu_seq_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count;

   // Saturating cycle counter; clear has priority over counting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= 8'd0;
      end else if (en && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count >= LIMIT);

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: pops instructions, reads two operands, issues them to the ALU core
// and pushes each result into the result FIFO, reporting op_done or fault to the slave.
// Optional feature macro: ALU_SEQ_PERF_CNT_EN builds the retired-instruction counter;
// without it inst_count is tied to zero.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DW      = DW_DEFAULT,
   parameter int TIMEOUT = 16
) (
   input logic            clk,
   input logic            reset_n,
   alu_sequencer_if.master bus
);

   seq_state_t    state;
   seq_state_t    state_next;
   logic [15:0]   inst_q;
   logic [DW-1:0] alu_a_q;
   logic [DW-1:0] alu_b_q;
   logic [DW-1:0] r_din_q;

   logic       inst_rd_en;
   logic       alu_start;
   logic       r_wr_en;
   logic       op_done;
   logic       fault;
   logic [3:0] alu_op;
   logic       wd_clr;
   logic       wd_en;
   logic       wd_expired;
   logic       load_inst;
   logic       load_ops;
   logic       load_res;

   alu_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // State register; an asynchronous reset aborts whatever is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the one-cycle strobes and capture enables of each state.
   always_comb begin
      state_next = state;
      inst_rd_en = 1'b0;
      alu_start  = 1'b0;
      r_wr_en    = 1'b0;
      op_done    = 1'b0;
      fault      = 1'b0;
      alu_op     = 4'h0;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
      load_inst  = 1'b0;
      load_ops   = 1'b0;
      load_res   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.op_start) begin
               state_next = bus.inst_empty ? S_FAULT : S_FETCH;
            end
         end
         S_FETCH: begin
            inst_rd_en = 1'b1;
            state_next = S_LATCH;
         end
         S_LATCH: begin
            load_inst = 1'b1;
            if (inst_opcode(bus.inst_dout[15:0]) == OP_NOP) begin
               state_next = bus.inst_empty ? S_DONE : S_FETCH;
            end else begin
               state_next = S_READ;
            end
         end
         S_READ: begin
            load_ops   = 1'b1;
            state_next = S_ISSUE;
         end
         S_ISSUE: begin
            alu_start  = 1'b1;
            alu_op     = inst_opcode(inst_q);
            wd_clr     = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            alu_op = inst_opcode(inst_q);
            if (bus.alu_done) begin
               load_res   = 1'b1;
               state_next = S_WRITE;
            end else begin
               wd_en = 1'b1;
               if (wd_expired) begin
                  state_next = S_FAULT;
               end
            end
         end
         S_WRITE: begin
            if (!bus.r_full) begin
               r_wr_en    = 1'b1;
               state_next = bus.inst_empty ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            op_done    = 1'b1;
            state_next = S_IDLE;
         end
         S_FAULT: begin
            fault      = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath captures: instruction, operand pair and ALU result each load in their own state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_q  <= 16'd0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         r_din_q <= '0;
      end else begin
         if (load_inst) begin
            inst_q <= bus.inst_dout[15:0];
         end
         if (load_ops) begin
            alu_a_q <= bus.rf_data_a;
            alu_b_q <= bus.rf_data_b;
         end
         if (load_res) begin
            r_din_q <= bus.alu_result;
         end
      end
   end

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [31:0] inst_count_q;
   logic        count_clear;
   logic        count_inc;

   assign count_clear = (state == S_IDLE) && bus.op_start && !bus.inst_empty;
   assign count_inc   = r_wr_en ||
                        ((state == S_LATCH) && (inst_opcode(bus.inst_dout[15:0]) == OP_NOP));

   // Retired-instruction counter: results written plus NOPs retired, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_count_q <= 32'd0;
      end else if (count_clear) begin
         inst_count_q <= 32'd0;
      end else if (count_inc) begin
         inst_count_q <= inst_count_q + 32'd1;
      end
   end

   assign bus.inst_count = inst_count_q;
`else
   assign bus.inst_count = 32'd0;
`endif

   assign bus.inst_rd_en = inst_rd_en;
   assign bus.rf_addr_a  = inst_src_a(inst_q);
   assign bus.rf_addr_b  = inst_src_b(inst_q);
   assign bus.alu_op     = alu_op;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_start  = alu_start;
   assign bus.r_wr_en    = r_wr_en;
   assign bus.r_din      = r_din_q;
   assign bus.op_done    = op_done;
   assign bus.fault      = fault;
   assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: models the instruction FIFO, register file, ALU core and
// result FIFO around the design, and predicts results and timing from the program itself.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   alu_sequencer_if #(.DW(DW)) bus();

   alu_sequencer #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   logic [DW-1:0] rf [16];
   assign bus.rf_data_a = rf[bus.rf_addr_a];
   assign bus.rf_data_b = rf[bus.rf_addr_b];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [31:0] prog[$];
   int          latProg[$];
   logic [31:0] fifo[$];
   logic [3:0]  expOp[$];
   logic [31:0] expA[$];
   logic [31:0] expB[$];
   logic [31:0] expRes[$];
   logic [31:0] aluOut[$];
   int          latQ[$];

   int          issueCyc = -1;
   int          curLat = 0;
   logic [31:0] curRes = 32'd0;
   int          fullPct = 0;
   int          fullFrom = 1;
   int          fullTo = 0;
   bit          holdOn = 1'b0;
   logic [31:0] holdVal = 32'd0;
   int          midStart = -1;

   int firstRd, firstStart, firstWr, doneCyc, faultCyc;
   int pushCount, doneCount, faultCount, rdCount;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behaviour of the ALU core as the environment sees it.
   function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      if (op == 4'h1) return a + b;
      return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
   endfunction

   function automatic int expCount(input int n);
`ifdef ALU_SEQ_PERF_CNT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic loadProgram();
      logic [3:0] op;
      logic [31:0] a, b;
      fifo = prog;
      expOp.delete(); expA.delete(); expB.delete(); expRes.delete();
      aluOut.delete(); latQ.delete();
      foreach (prog[i]) begin
         op = prog[i][15:12];
         if (op != OP_NOP) begin
            a = rf[prog[i][7:4]];
            b = rf[prog[i][3:0]];
            expOp.push_back(op);
            expA.push_back(a);
            expB.push_back(b);
            expRes.push_back(aluModel(op, a, b));
            aluOut.push_back(aluModel(op, a, b));
            latQ.push_back(latProg[i]);
         end
      end
      bus.inst_empty = (fifo.size() == 0);
      issueCyc = -1; curLat = 0;
      firstRd = -1; firstStart = -1; firstWr = -1; doneCyc = -1; faultCyc = -1;
      pushCount = 0; doneCount = 0; faultCount = 0; rdCount = 0;
   endtask

   task automatic observe();
      if (bus.inst_rd_en) begin
         rdCount++;
         if (firstRd < 0) firstRd = cyc;
      end
      if (bus.alu_start) begin
         if (expOp.size() > 0) begin
            checkOutput("alu_op", bus.alu_op, expOp.pop_front());
            checkOutput("alu_a", bus.alu_a, expA.pop_front());
            checkOutput("alu_b", bus.alu_b, expB.pop_front());
            curLat = latQ.pop_front();
            curRes = aluOut.pop_front();
         end else begin
            checkOutput("extra_issue", expOp.size(), 1);
            curLat = 0;
         end
         issueCyc = cyc;
         if (firstStart < 0) firstStart = cyc;
      end
      if (bus.r_wr_en) begin
         pushCount++;
         if (firstWr < 0) firstWr = cyc;
         if (expRes.size() > 0) checkOutput("r_din", bus.r_din, expRes.pop_front());
         else checkOutput("extra_push", expRes.size(), 1);
      end
      if (holdOn && bus.r_full && cyc >= fullFrom && cyc <= fullTo)
         checkOutput("r_din_hold", bus.r_din, holdVal);
      if (bus.op_done) begin
         doneCount++;
         doneCyc = cyc;
      end
      if (bus.fault) begin
         faultCount++;
         faultCyc = cyc;
      end
   endtask

   // One clock: advance the environment models after the edge, then sample the DUT.
   task automatic tick();
      logic rdSeen;
      rdSeen = bus.inst_rd_en;
      @(posedge clk);
      #1;
      cyc++;
      bus.op_start = (cyc == midStart);
      if (rdSeen) begin
         if (fifo.size() > 0) bus.inst_dout = fifo.pop_front();
         else bus.inst_dout = $urandom;
      end
      bus.inst_empty = (fifo.size() == 0);
      if (issueCyc >= 0 && curLat > 0 && cyc == issueCyc + curLat) begin
         bus.alu_done = 1'b1;
         bus.alu_result = curRes;
      end else begin
         bus.alu_done = 1'b0;
         bus.alu_result = $urandom;
      end
      bus.r_full = (cyc >= fullFrom && cyc <= fullTo) || ($urandom_range(0, 99) < fullPct);
      #1;
      observe();
   endtask

   task automatic runUntilIdle(input int budget);
      do tick(); while (bus.busy && cyc < budget);
      checkOutput("idle_at_end", bus.busy, 0);
   endtask

   task automatic applyStimulus(input int pct, input int budget);
      loadProgram();
      fullPct = pct;
      cyc = 0;
      bus.op_start = 1'b1;
      runUntilIdle(budget);
   endtask

   task automatic setOne(input logic [31:0] inst, input int lat);
      prog.delete(); latProg.delete();
      prog.push_back(inst); latProg.push_back(lat);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int len, nonNop, expDone, lat;
      logic [3:0] op;
      logic [31:0] word;

      bus.op_start = 1'b0; bus.inst_empty = 1'b1; bus.inst_dout = '0;
      bus.alu_done = 1'b0; bus.alu_result = '0; bus.r_full = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = $urandom;

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ctrl", {bus.busy, bus.inst_rd_en, bus.alu_start, bus.r_wr_en,
                               bus.op_done, bus.fault}, 0);
      checkOutput("rst_alu_a", bus.alu_a, 0);
      checkOutput("rst_alu_b", bus.alu_b, 0);
      checkOutput("rst_r_din", bus.r_din, 0);
      checkOutput("rst_addr_op", {bus.alu_op, bus.rf_addr_a, bus.rf_addr_b}, 0);
      checkOutput("rst_count", bus.inst_count, 0);
      reset_n = 1'b1;
      @(posedge clk); #2;

      $display("[TB] single instruction latency");
      rf[1] = 32'd5; rf[2] = 32'd7;
      setOne(32'h0000_1012, 1);
      applyStimulus(0, 40);
      checkOutput("t1_rd_cycle", firstRd, 1);
      checkOutput("t1_start_cycle", firstStart, 4);
      checkOutput("t1_wr_cycle", firstWr, 6);
      checkOutput("t1_done_cycle", doneCyc, 7);
      checkOutput("t1_idle_cycle", cyc, 8);
      checkOutput("t1_pushes", pushCount, 1);
      checkOutput("t1_faults", faultCount, 0);
      checkOutput("t1_count", bus.inst_count, expCount(1));

      $display("[TB] start with empty FIFO");
      prog.delete(); latProg.delete();
      applyStimulus(0, 20);
      checkOutput("t2_fault_cycle", faultCyc, 1);
      checkOutput("t2_reads", rdCount, 0);
      checkOutput("t2_idle_cycle", cyc, 2);
      checkOutput("t2_done", doneCount, 0);

      $display("[TB] chained instructions with a NOP");
      prog.delete(); latProg.delete();
      prog.push_back(32'h0000_3021); latProg.push_back(2);
      prog.push_back(32'h0000_0000); latProg.push_back(0);
      prog.push_back(32'h0000_5310); latProg.push_back(1);
      applyStimulus(0, 60);
      checkOutput("t3_pushes", pushCount, 2);
      checkOutput("t3_done", doneCount, 1);
      checkOutput("t3_faults", faultCount, 0);
      checkOutput("t3_done_cycle", doneCyc, 16);
      checkOutput("t3_count", bus.inst_count, expCount(3));

      $display("[TB] result FIFO full backpressure");
      setOne(32'h0000_1012, 1);
      fullFrom = 6; fullTo = 10; holdOn = 1'b1; holdVal = 32'd12;
      applyStimulus(0, 40);
      fullFrom = 1; fullTo = 0; holdOn = 1'b0;
      checkOutput("t4_wr_cycle", firstWr, 11);
      checkOutput("t4_pushes", pushCount, 1);
      checkOutput("t4_done_cycle", doneCyc, 12);

      $display("[TB] ALU timeout");
      setOne(32'h0000_7045, 0);
      applyStimulus(0, 60);
      checkOutput("t5_fault_cycle", faultCyc, 21);
      checkOutput("t5_pushes", pushCount, 0);
      checkOutput("t5_done", doneCount, 0);

      $display("[TB] alu_done on expiry cycle");
      setOne(32'h0000_7045, 16);
      applyStimulus(0, 60);
      checkOutput("t5b_wr_cycle", firstWr, 21);
      checkOutput("t5b_done_cycle", doneCyc, 22);
      checkOutput("t5b_faults", faultCount, 0);

      $display("[TB] reset during WAIT");
      setOne(32'h0000_2034, 0);
      loadProgram();
      cyc = 0;
      bus.op_start = 1'b1;
      repeat (7) tick();
      reset_n = 1'b0;
      #1;
      checkOutput("t6_rst_ctrl", {bus.busy, bus.inst_rd_en, bus.alu_start, bus.r_wr_en,
                                  bus.op_done, bus.fault, bus.alu_op}, 0);
      checkOutput("t6_rst_alu_a", bus.alu_a, 0);
      checkOutput("t6_rst_alu_b", bus.alu_b, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      bus.alu_done = 1'b0;
      @(posedge clk); #2;
      setOne(32'h0000_1012, 1);
      midStart = 3;
      applyStimulus(0, 40);
      midStart = -1;
      checkOutput("t6_done_cycle", doneCyc, 7);
      checkOutput("t6_reads", rdCount, 1);
      checkOutput("t6_done", doneCount, 1);
      checkOutput("t6_faults", faultCount, 0);
      checkOutput("t6_pushes", pushCount, 1);

      $display("[TB] randomized programs");
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 16; i++) rf[i] = $urandom;
         prog.delete(); latProg.delete();
         len = $urandom_range(1, 5);
         nonNop = 0;
         expDone = 1;
         for (int i = 0; i < len; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            word = $urandom;
            word[15:12] = op;
            lat = $urandom_range(1, 6);
            prog.push_back(word);
            latProg.push_back(lat);
            if (op == OP_NOP) begin
               expDone += 2;
            end else begin
               nonNop++;
               expDone += 5 + lat;
            end
         end
         applyStimulus((t % 2 == 1) ? 30 : 0, 500);
         checkOutput("rnd_pushes", pushCount, nonNop);
         checkOutput("rnd_done", doneCount, 1);
         checkOutput("rnd_faults", faultCount, 0);
         checkOutput("rnd_left", expRes.size(), 0);
         checkOutput("rnd_count", bus.inst_count, expCount(len));
         if (t % 2 == 0) checkOutput("rnd_done_cycle", doneCyc, expDone);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
